ahb_lite_arbiter: RTL and testbench



---
 rtl/ahb_arb_pkg.sv | 42 ++++
 rtl/ahb_rr_picker.sv | 28 ++
 rtl/ahb_lite_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_ahb_lite_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared encodings and helpers for the AHB-Lite multi-master arbiter.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam int BEAT_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_S    = 2'd0,
    BURST_S  = 2'd1,
    LOCKED_S = 2'd2
  } arb_state_e;

  // Remaining beats after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
  function automatic logic [BEAT_CNT_W-1:0] burst_len_m1(input logic [2:0] hburst);
    logic [BEAT_CNT_W-1:0] len;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  len = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  len = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: len = 4'd15;
      default:                      len = 4'd0;
    endcase
    return len;
  endfunction

  function automatic logic burst_is_fixed(input logic [2:0] hburst);
    return (burst_len_m1(hburst) != 4'd0);
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin picker: first requester strictly after last_i (mod N), one-hot result.
module ahb_rr_picker #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o
);

  logic found_s;
  logic hit_s;

  // The last owner is visited at offset N, so it only wins when nobody else asks.
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        hit_s      = req_i[j] & ~found_s & (j == ((int'(last_i) + k) % N));
        grant_o[j] = grant_o[j] | hit_s;
        found_s    = found_s | hit_s;
      end
    end
  end

endmodule

// File: rtl/ahb_lite_arbiter.sv
// AHB-Lite arbiter: round-robin grant, fixed-burst and locked-sequence holding,
// address-phase mux by hmaster and write-data mux by the data-phase owner.
module ahb_lite_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MST     = 2,
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic [NUM_MST-1:0]             m_hbusreq,
  input  logic [NUM_MST-1:0]             m_hlock,
  input  logic [NUM_MST*HADDR_WIDTH-1:0] m_haddr,
  input  logic [NUM_MST*2-1:0]           m_htrans,
  input  logic [NUM_MST*3-1:0]           m_hburst,
  input  logic [NUM_MST*3-1:0]           m_hsize,
  input  logic [NUM_MST*4-1:0]           m_hprot,
  input  logic [NUM_MST-1:0]             m_hwrite,
  input  logic [NUM_MST*HDATA_WIDTH-1:0] m_hwdata,
  output logic [NUM_MST-1:0]             m_hgrant,
  output logic [HADDR_WIDTH-1:0]         Haddr,
  output logic [1:0]                     Htrans,
  output logic [2:0]                     Hburst,
  output logic [2:0]                     Hsize,
  output logic [3:0]                     Hprot,
  output logic                           Hwrite,
  output logic                           Hmastlock,
  output logic [HDATA_WIDTH-1:0]         Hwdata,
  input  logic                           Hready_out,
  input  logic                           Hresp,
  output logic [$clog2(NUM_MST)-1:0]     hmaster
);

  localparam int IW = $clog2(NUM_MST);

  logic [HADDR_WIDTH-1:0] addr_a  [NUM_MST];
  logic [HDATA_WIDTH-1:0] wdata_a [NUM_MST];
  logic [1:0]             trans_a [NUM_MST];
  logic [2:0]             burst_a [NUM_MST];
  logic [2:0]             size_a  [NUM_MST];
  logic [3:0]             prot_a  [NUM_MST];

  for (genvar g = 0; g < NUM_MST; g++) begin : g_unpack
    assign addr_a[g]  = m_haddr[g*HADDR_WIDTH +: HADDR_WIDTH];
    assign wdata_a[g] = m_hwdata[g*HDATA_WIDTH +: HDATA_WIDTH];
    assign trans_a[g] = m_htrans[g*2 +: 2];
    assign burst_a[g] = m_hburst[g*3 +: 3];
    assign size_a[g]  = m_hsize[g*3 +: 3];
    assign prot_a[g]  = m_hprot[g*4 +: 4];
  end

  arb_state_e            state_q,   state_d;
  logic [IW-1:0]         hmaster_q, hmaster_d;
  logic [IW-1:0]         dmaster_q, dmaster_d;
  logic [BEAT_CNT_W-1:0] cnt_q,     cnt_d;

  logic [NUM_MST-1:0] pick_oh_s;
  logic [IW-1:0]      pick_idx_s;
  logic [IW-1:0]      arb_target_s;
  logic               any_req_s;
  logic               own_req_s;
  logic               own_lock_s;
  logic [1:0]         htrans_s;
  logic [2:0]         own_burst_s;
  logic               idle_s, busy_s, nonseq_s, seq_s;

  ahb_rr_picker #(.N(NUM_MST), .IW(IW)) u_picker (
    .req_i   (m_hbusreq),
    .last_i  (hmaster_q),
    .grant_o (pick_oh_s)
  );

  // One-hot winner to index.
  always_comb begin
    pick_idx_s = '0;
    for (int j = 0; j < NUM_MST; j++) begin
      pick_idx_s = pick_idx_s | ({IW{pick_oh_s[j]}} & IW'(j));
    end
  end

  assign any_req_s    = |m_hbusreq;
  assign arb_target_s = any_req_s ? pick_idx_s : hmaster_q;
  assign own_req_s    = m_hbusreq[hmaster_q];
  assign own_lock_s   = m_hlock[hmaster_q];
  assign own_burst_s  = burst_a[hmaster_q];

  // A parked owner that is not requesting must not leak transfers onto the bus.
  assign htrans_s = (hreset || ((state_q == ARB_S) && !own_req_s)) ? HTRANS_IDLE
                                                                    : trans_a[hmaster_q];
  assign idle_s   = (htrans_s == HTRANS_IDLE);
  assign busy_s   = (htrans_s == HTRANS_BUSY);
  assign nonseq_s = (htrans_s == HTRANS_NONSEQ);
  assign seq_s    = (htrans_s == HTRANS_SEQ);

  // State register.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= ARB_S;
      hmaster_q <= '0;
      dmaster_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hmaster_q <= hmaster_d;
      dmaster_q <= dmaster_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state: everything freezes while the slave inserts wait states.
  always_comb begin
    state_d   = state_q;
    hmaster_d = hmaster_q;
    dmaster_d = dmaster_q;
    cnt_d     = cnt_q;
    if (Hready_out) begin
      dmaster_d = hmaster_q;
      case (state_q)
        ARB_S: begin
          if (nonseq_s && own_lock_s) begin
            state_d = LOCKED_S;
          end else if (nonseq_s && burst_is_fixed(own_burst_s)) begin
            state_d = BURST_S;
            cnt_d   = burst_len_m1(own_burst_s);
          end else if (own_req_s && (seq_s || busy_s)) begin
            hmaster_d = hmaster_q;
          end else begin
            hmaster_d = arb_target_s;
          end
        end
        BURST_S: begin
          if (Hresp) begin
            state_d   = ARB_S;
            cnt_d     = '0;
            hmaster_d = arb_target_s;
          end else if (nonseq_s && own_lock_s) begin
            state_d = LOCKED_S;
            cnt_d   = '0;
          end else if (seq_s) begin
            cnt_d = (cnt_q == 4'd0) ? 4'd0 : (cnt_q - 4'd1);
            if (cnt_q <= 4'd1) begin
              state_d   = ARB_S;
              hmaster_d = arb_target_s;
            end else begin
              state_d = BURST_S;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        LOCKED_S: begin
          if (!own_lock_s && (idle_s || nonseq_s)) begin
            state_d   = ARB_S;
            hmaster_d = arb_target_s;
          end else begin
            state_d = LOCKED_S;
          end
        end
        default: begin
          state_d = ARB_S;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Outputs: address phase follows hmaster, write data follows the data-phase owner.
  always_comb begin
    Haddr     = addr_a[hmaster_q];
    Htrans    = htrans_s;
    Hburst    = burst_a[hmaster_q];
    Hsize     = size_a[hmaster_q];
    Hprot     = prot_a[hmaster_q];
    Hwrite    = m_hwrite[hmaster_q];
    Hmastlock = (state_q == LOCKED_S);
    Hwdata    = wdata_a[dmaster_q];
    hmaster   = hmaster_q;
    m_hgrant  = '0;
    for (int j = 0; j < NUM_MST; j++) begin
      m_hgrant[j] = (hmaster_q == IW'(j));
    end
  end

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Directed scenario bench for ahb_lite_arbiter with two masters.
module tb_ahb_lite_arbiter;
  import ahb_arb_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [1:0]  m_hbusreq, m_hlock, m_hwrite;
  logic [1:0]  tr_b [2];
  logic [2:0]  bu_b [2];
  logic [2:0]  sz_b [2];
  logic [3:0]  pr_b [2];
  logic [31:0] ad_b [2];
  logic [31:0] wd_b [2];
  logic [63:0] m_haddr, m_hwdata;
  logic [3:0]  m_htrans;
  logic [5:0]  m_hburst, m_hsize;
  logic [7:0]  m_hprot;
  logic [1:0]  m_hgrant;
  logic [31:0] Haddr, Hwdata;
  logic [1:0]  Htrans;
  logic [2:0]  Hburst, Hsize;
  logic [3:0]  Hprot;
  logic        Hwrite, Hmastlock, Hready_out, Hresp;
  logic        hmaster;

  int total = 0;
  int bad   = 0;

  assign m_haddr  = {ad_b[1], ad_b[0]};
  assign m_hwdata = {wd_b[1], wd_b[0]};
  assign m_htrans = {tr_b[1], tr_b[0]};
  assign m_hburst = {bu_b[1], bu_b[0]};
  assign m_hsize  = {sz_b[1], sz_b[0]};
  assign m_hprot  = {pr_b[1], pr_b[0]};

  ahb_lite_arbiter #(.NUM_MST(2), .HADDR_WIDTH(32), .HDATA_WIDTH(32)) dut (
    .hclk(hclk), .hreset(hreset), .m_hbusreq(m_hbusreq), .m_hlock(m_hlock),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hburst(m_hburst), .m_hsize(m_hsize),
    .m_hprot(m_hprot), .m_hwrite(m_hwrite), .m_hwdata(m_hwdata), .m_hgrant(m_hgrant),
    .Haddr(Haddr), .Htrans(Htrans), .Hburst(Hburst), .Hsize(Hsize), .Hprot(Hprot),
    .Hwrite(Hwrite), .Hmastlock(Hmastlock), .Hwdata(Hwdata), .Hready_out(Hready_out),
    .Hresp(Hresp), .hmaster(hmaster)
  );

  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drv(input logic m, input logic req, input logic [1:0] tr,
                     input logic [2:0] bu, input logic [31:0] ad);
    m_hbusreq[m] = req;
    tr_b[m]      = tr;
    bu_b[m]      = bu;
    ad_b[m]      = ad;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    drv(1'b0, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_0010);
    drv(1'b1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_0020);
    repeat (2) tick();
    total++; if (m_hgrant !== 2'b01) begin bad++; $display("FAIL reset_grant got=%b want=01", m_hgrant); end
    total++; if (hmaster !== 1'b0) begin bad++; $display("FAIL reset_hmaster got=%0d want=0", hmaster); end
    total++; if (Htrans !== HTRANS_IDLE) begin bad++; $display("FAIL reset_htrans got=%b want=00", Htrans); end
    total++; if (Hmastlock !== 1'b0) begin bad++; $display("FAIL reset_mastlock got=%b want=0", Hmastlock); end
  endtask

  task automatic test_park();
    drv(1'b0, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_0010);
    hreset = 1'b0;
    tick();
    total++; if (m_hgrant !== 2'b01) begin bad++; $display("FAIL park_grant got=%b want=01", m_hgrant); end
    total++; if (Htrans !== HTRANS_IDLE) begin bad++; $display("FAIL park_idle got=%b want=00", Htrans); end
  endtask

  task automatic test_burst_handover();
    drv(1'b0, 1'b1, HTRANS_NONSEQ, HBURST_INCR4, 32'h0000_0100);
    drv(1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR, 32'h0000_0200);
    settle();
    total++; if (Haddr !== 32'h0000_0100) begin bad++; $display("FAIL ho_first_addr got=%h want=00000100", Haddr); end
    total++; if (Htrans !== HTRANS_NONSEQ) begin bad++; $display("FAIL ho_first_trans got=%b want=10", Htrans); end
    tick();
    for (int b = 2; b <= 4; b++) begin
      drv(1'b0, 1'b1, HTRANS_SEQ, HBURST_INCR4, 32'h0000_0100 + 32'(4 * (b - 1)));
      settle();
      total++; if (m_hgrant !== 2'b01) begin bad++; $display("FAIL ho_hold_beat%0d got=%b want=01", b, m_hgrant); end
      tick();
    end
    drv(1'b0, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_0000);
    settle();
    total++; if (hmaster !== 1'b1) begin bad++; $display("FAIL ho_switch got=%0d want=1", hmaster); end
    total++; if (Htrans !== HTRANS_NONSEQ) begin bad++; $display("FAIL ho_m1_trans got=%b want=10", Htrans); end
    total++; if (Haddr !== 32'h0000_0200) begin bad++; $display("FAIL ho_m1_addr got=%h want=00000200", Haddr); end
  endtask

  task automatic test_wait_states();
    drv(1'b1, 1'b1, HTRANS_NONSEQ, HBURST_WRAP8, 32'h0000_0020);
    drv(1'b0, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_0300);
    tick();
    drv(1'b1, 1'b1, HTRANS_SEQ, HBURST_WRAP8, 32'h0000_0024);
    Hready_out = 1'b0;
    repeat (3) begin
      tick();
      total++; if (m_hgrant !== 2'b10) begin bad++; $display("FAIL ws_grant got=%b want=10", m_hgrant); end
      total++; if (Haddr !== 32'h0000_0024) begin bad++; $display("FAIL ws_addr got=%h want=00000024", Haddr); end
    end
    Hready_out = 1'b1;
    tick();
    for (int b = 3; b <= 8; b++) begin
      drv(1'b1, 1'b1, HTRANS_SEQ, HBURST_WRAP8, 32'h0000_0020 + 32'(4 * (b - 1)));
      settle();
      total++; if (m_hgrant !== 2'b10) begin bad++; $display("FAIL ws_hold_beat%0d got=%b want=10", b, m_hgrant); end
      tick();
    end
    settle();
    total++; if (hmaster !== 1'b0) begin bad++; $display("FAIL ws_done_owner got=%0d want=0", hmaster); end
    total++; if (Haddr !== 32'h0000_0300) begin bad++; $display("FAIL ws_done_addr got=%h want=00000300", Haddr); end
  endtask

  task automatic test_locked();
    m_hlock = 2'b01;
    drv(1'b0, 1'b1, HTRANS_NONSEQ, HBURST_INCR, 32'h0000_0400);
    drv(1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR, 32'h0000_0900);
    tick();
    drv(1'b0, 1'b1, HTRANS_SEQ, HBURST_INCR, 32'h0000_0404);
    settle();
    total++; if (Hmastlock !== 1'b1) begin bad++; $display("FAIL lk_mastlock got=%b want=1", Hmastlock); end
    total++; if (m_hgrant !== 2'b01) begin bad++; $display("FAIL lk_grant got=%b want=01", m_hgrant); end
    tick();
    m_hlock = 2'b00;
    drv(1'b0, 1'b1, HTRANS_SEQ, HBURST_INCR, 32'h0000_0408);
    tick();
    drv(1'b0, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_0000);
    settle();
    total++; if (Hmastlock !== 1'b1) begin bad++; $display("FAIL lk_after_drop got=%b want=1", Hmastlock); end
    total++; if (hmaster !== 1'b0) begin bad++; $display("FAIL lk_blocked got=%0d want=0", hmaster); end
    tick();
    total++; if (Hmastlock !== 1'b0) begin bad++; $display("FAIL lk_release got=%b want=0", Hmastlock); end
    total++; if (hmaster !== 1'b1) begin bad++; $display("FAIL lk_m1_owner got=%0d want=1", hmaster); end
    total++; if (Haddr !== 32'h0000_0900) begin bad++; $display("FAIL lk_m1_addr got=%h want=00000900", Haddr); end
  endtask

  task automatic test_error();
    drv(1'b1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_0000);
    drv(1'b0, 1'b1, HTRANS_NONSEQ, HBURST_INCR8, 32'h0000_0500);
    settle();
    total++; if (Htrans !== HTRANS_IDLE) begin bad++; $display("FAIL er_park_idle got=%b want=00", Htrans); end
    tick();
    drv(1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_0A00);
    settle();
    total++; if (Haddr !== 32'h0000_0500) begin bad++; $display("FAIL er_m0_addr got=%h want=00000500", Haddr); end
    tick();
    drv(1'b0, 1'b1, HTRANS_SEQ, HBURST_INCR8, 32'h0000_0504);
    Hready_out = 1'b0;
    Hresp      = 1'b1;
    tick();
    drv(1'b0, 1'b1, HTRANS_IDLE, HBURST_INCR8, 32'h0000_0508);
    Hready_out = 1'b1;
    settle();
    total++; if (hmaster !== 1'b0) begin bad++; $display("FAIL er_first_cycle got=%0d want=0", hmaster); end
    tick();
    Hresp = 1'b0;
    settle();
    total++; if (m_hgrant !== 2'b10) begin bad++; $display("FAIL er_m1_grant got=%b want=10", m_hgrant); end
    total++; if (Haddr !== 32'h0000_0A00) begin bad++; $display("FAIL er_m1_addr got=%h want=00000a00", Haddr); end
  endtask

  task automatic test_back_to_back();
    m_hwrite = 2'b11;
    wd_b[0]  = 32'hAAAA_0000;
    wd_b[1]  = 32'h1111_0000;
    sz_b[0]  = 3'd2;
    sz_b[1]  = 3'd1;
    drv(1'b1, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_0000);
    drv(1'b0, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_0600);
    tick();
    drv(1'b1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 32'h0000_0700);
    settle();
    total++; if (Haddr !== 32'h0000_0600) begin bad++; $display("FAIL bb_m0_addr got=%h want=00000600", Haddr); end
    total++; if (Hsize !== 3'd2) begin bad++; $display("FAIL bb_m0_size got=%0d want=2", Hsize); end
    tick();
    drv(1'b0, 1'b0, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_0000);
    settle();
    total++; if (Hwdata !== 32'hAAAA_0000) begin bad++; $display("FAIL bb_m0_wdata got=%h want=aaaa0000", Hwdata); end
    total++; if (Haddr !== 32'h0000_0700) begin bad++; $display("FAIL bb_m1_addr got=%h want=00000700", Haddr); end
    total++; if (Hsize !== 3'd1) begin bad++; $display("FAIL bb_m1_size got=%0d want=1", Hsize); end
    tick();
    drv(1'b1, 1'b1, HTRANS_IDLE, HBURST_SINGLE, 32'h0000_0000);
    settle();
    total++; if (Hwdata !== 32'h1111_0000) begin bad++; $display("FAIL bb_m1_wdata got=%h want=11110000", Hwdata); end
  endtask

  task automatic test_reset_midburst();
    drv(1'b1, 1'b1, HTRANS_NONSEQ, HBURST_INCR4, 32'h0000_0800);
    tick();
    drv(1'b1, 1'b1, HTRANS_SEQ, HBURST_INCR4, 32'h0000_0804);
    tick();
    drv(1'b1, 1'b1, HTRANS_SEQ, HBURST_INCR4, 32'h0000_0808);
    hreset = 1'b1;
    settle();
    total++; if (Htrans !== HTRANS_IDLE) begin bad++; $display("FAIL rm_forced_idle got=%b want=00", Htrans); end
    tick();
    total++; if (m_hgrant !== 2'b01) begin bad++; $display("FAIL rm_grant got=%b want=01", m_hgrant); end
    hreset = 1'b0;
    settle();
    total++; if (Htrans !== HTRANS_IDLE) begin bad++; $display("FAIL rm_no_beats got=%b want=00", Htrans); end
    tick();
    total++; if (hmaster !== 1'b1) begin bad++; $display("FAIL rm_first_arb got=%0d want=1", hmaster); end
  endtask

  initial begin
    hreset     = 1'b1;
    Hready_out = 1'b1;
    Hresp      = 1'b0;
    m_hbusreq  = 2'b00;
    m_hlock    = 2'b00;
    m_hwrite   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      tr_b[i] = HTRANS_IDLE;
      bu_b[i] = HBURST_SINGLE;
      sz_b[i] = 3'd2;
      pr_b[i] = 4'h3;
      ad_b[i] = 32'h0;
      wd_b[i] = 32'h0;
    end
    test_reset();
    test_park();
    test_burst_handover();
    test_wait_states();
    test_locked();
    test_error();
    test_back_to_back();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
